cordic_arbiter: RTL and testbench

CORDIC_ARBITER -- requirements
Module: cordic_arbiter

---
 rtl/cordic_pkg.sv | 20 ++
 rtl/rr_arbiter2.sv | 28 ++
 rtl/cordic_arbiter.sv | 161 ++++++++++++++++
 tb/tb_cordic_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// ---------------------------------------------------------------------------
// cordic_pkg
// Shared definitions for the CORDIC request arbiter slice.
//   ANGLE_W     : default angle / result width
//   TIMEOUT_DEF : default number of WAIT cycles before a core timeout
//   state_e     : arbiter FSM state encoding (IDLE is all-zero)
// ---------------------------------------------------------------------------
package cordic_pkg;

   localparam int ANGLE_W     = 18;
   localparam int TIMEOUT_DEF = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
// Two-way round-robin grant, purely combinational.
//   valid0_i / valid1_i : request present on port 0 / 1
//   last_i              : index of the requester granted most recently
//   grant_o             : one-hot grant (bit 0 -> port 0, bit 1 -> port 1),
//                         all-zero when nothing is requesting
// ---------------------------------------------------------------------------
module rr_arbiter2 (
   input  logic       valid0_i,
   input  logic       valid1_i,
   input  logic       last_i,
   output logic [1:0] grant_o
);

   always_comb begin
      grant_o = 2'b00;
      if (valid0_i && valid1_i) begin
         // On a tie, favour whoever did not win last time.
         grant_o = last_i ? 2'b01 : 2'b10;
      end else if (valid0_i) begin
         grant_o = 2'b01;
      end else if (valid1_i) begin
         grant_o = 2'b10;
      end
   end

endmodule

// File: rtl/cordic_arbiter.sv
// ---------------------------------------------------------------------------
// cordic_arbiter
// Shares one external iterative CORDIC core between two requesters.
// A request is accepted in IDLE, its angle launched with a one-cycle start
// pulse, the core result (or a timeout error) is captured and offered on the
// response port until the consumer takes it.
//
// Handshake rule (all ports): a transfer happens on a rising clock edge where
// valid && ready are both high. The response side holds rsp_valid and every
// rsp_* field stable until that edge.
//
// Ports
//   clock, reset_n           : clock, synchronous active-low reset
//   req0_* / req1_*          : request ports (valid/ready/angle)
//   core_start, core_angle   : launch pulse and operand for the core
//   core_done, core_cos/sin  : core result strobe and data
//   rsp_*                    : response (valid/ready/id/cos/sin/err)
//   busy                     : FSM is not in IDLE
//   dbg_state                : current FSM state (state_e encoding)
// ---------------------------------------------------------------------------
module cordic_arbiter #(
   parameter int ANGLE_W = cordic_pkg::ANGLE_W,
   parameter int TIMEOUT = cordic_pkg::TIMEOUT_DEF
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               req0_valid,
   output logic               req0_ready,
   input  logic [ANGLE_W-1:0] req0_angle,
   input  logic               req1_valid,
   output logic               req1_ready,
   input  logic [ANGLE_W-1:0] req1_angle,
   output logic               core_start,
   output logic [ANGLE_W-1:0] core_angle,
   input  logic               core_done,
   input  logic [ANGLE_W-1:0] core_cos,
   input  logic [ANGLE_W-1:0] core_sin,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic               rsp_id,
   output logic [ANGLE_W-1:0] rsp_cos,
   output logic [ANGLE_W-1:0] rsp_sin,
   output logic               rsp_err,
   output logic               busy,
   output logic [1:0]         dbg_state
);

   import cordic_pkg::*;

   localparam int               CNT_W   = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_END = CNT_W'(TIMEOUT - 1);

   state_e             state_q, state_d;
   logic               last_q, last_d;
   logic               id_q, id_d;
   logic [ANGLE_W-1:0] angle_q, angle_d;
   logic [ANGLE_W-1:0] cos_q, cos_d;
   logic [ANGLE_W-1:0] sin_q, sin_d;
   logic               err_q, err_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [1:0]         grant;

   rr_arbiter2 u_rr (
      .valid0_i (req0_valid),
      .valid1_i (req1_valid),
      .last_i   (last_q),
      .grant_o  (grant)
   );

   always_comb begin
      state_d    = state_q;
      last_d     = last_q;
      id_d       = id_q;
      angle_d    = angle_q;
      cos_d      = cos_q;
      sin_d      = sin_q;
      err_d      = err_q;
      cnt_d      = cnt_q;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      core_start = 1'b0;

      case (state_q)
         ST_IDLE: begin
            req0_ready = grant[0];
            req1_ready = grant[1];
            // Ready is only ever raised alongside the matching valid, so any
            // grant here is a completed handshake.
            if (|grant) begin
               id_d    = grant[1];
               last_d  = grant[1];
               angle_d = grant[1] ? req1_angle : req0_angle;
               state_d = ST_START;
            end
         end
         ST_START: begin
            core_start = 1'b1;
            cnt_d      = '0;
            state_d    = ST_WAIT;
         end
         ST_WAIT: begin
            if (core_done) begin
               cos_d   = core_cos;
               sin_d   = core_sin;
               err_d   = 1'b0;
               state_d = ST_RESP;
            end else if (cnt_q == CNT_END) begin
               // TIMEOUT-th WAIT cycle without a result: give up.
               cos_d   = '0;
               sin_d   = '0;
               err_d   = 1'b1;
               cnt_d   = CNT_MAX;
               state_d = ST_RESP;
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         last_q  <= 1'b1;  // next tie goes to req0
         id_q    <= 1'b0;
         angle_q <= '0;
         cos_q   <= '0;
         sin_q   <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         id_q    <= id_d;
         angle_q <= angle_d;
         cos_q   <= cos_d;
         sin_q   <= sin_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign core_angle = angle_q;
   assign rsp_valid  = (state_q == ST_RESP);
   assign rsp_id     = id_q;
   assign rsp_cos    = cos_q;
   assign rsp_sin    = sin_q;
   assign rsp_err    = err_q;
   assign busy       = (state_q != ST_IDLE);
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_cordic_arbiter.sv
module tb_cordic_arbiter;

   localparam int W  = 18;
   localparam int TO = 32;
   localparam int RW = 2 + 2 * W;

   logic         clock = 1'b0;
   logic         reset_n;
   logic         req0_valid, req0_ready, req1_valid, req1_ready;
   logic [W-1:0] req0_angle, req1_angle;
   logic         core_start, core_done;
   logic [W-1:0] core_angle, core_cos, core_sin;
   logic         rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
   logic [W-1:0] rsp_cos, rsp_sin;
   logic [1:0]   dbg_state;

   int checks = 0;
   int errors = 0;

   // Reference model state: index last granted; 1 after reset so a tie picks req0.
   bit model_last;
   // Expected responses, packed as {id, err, cos, sin}.
   logic [RW-1:0] exp_q[$];

   always #5 clock = ~clock;

   cordic_arbiter #(.ANGLE_W(W), .TIMEOUT(TO)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_angle (req0_angle),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_angle (req1_angle),
      .core_start (core_start),
      .core_angle (core_angle),
      .core_done  (core_done),
      .core_cos   (core_cos),
      .core_sin   (core_sin),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_cos    (rsp_cos),
      .rsp_sin    (rsp_sin),
      .rsp_err    (rsp_err),
      .busy       (busy),
      .dbg_state  (dbg_state)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic check_rsp(input logic [RW-1:0] exp);
      check_eq("rsp_valid", rsp_valid, 1);
      check_eq("rsp_id", rsp_id, exp[RW-1]);
      check_eq("rsp_err", rsp_err, exp[RW-2]);
      check_eq("rsp_cos", rsp_cos, exp[2*W-1:W]);
      check_eq("rsp_sin", rsp_sin, exp[W-1:0]);
      check_eq("ready0_resp", req0_ready, 0);
      check_eq("ready1_resp", req1_ready, 0);
   endtask

   // One full transaction, entered and left on a falling edge.
   // dly > 0: core_done is raised dly cycles after the start pulse cycle.
   // dly = 0: the core never answers (timeout). bp: cycles of rsp backpressure.
   task automatic run_txn(input bit v0, input bit v1, input logic [W-1:0] a0,
                          input logic [W-1:0] a1, input int dly, input int bp);
      bit            gid;
      logic [W-1:0]  ga, c, s;
      logic [RW-1:0] exp;
      int            limit;
      gid = (v0 && v1) ? !model_last : (v1 && !v0);
      ga  = gid ? a1 : a0;
      req0_valid = v0; req1_valid = v1;
      req0_angle = a0; req1_angle = a1;
      #1;
      check_eq("ready0_grant", req0_ready, (gid == 1'b0));
      check_eq("ready1_grant", req1_ready, (gid == 1'b1));
      @(posedge clock);
      model_last = gid;
      @(negedge clock);
      if (gid) req1_valid = 1'b0; else req0_valid = 1'b0;
      #1;
      check_eq("core_start_pulse", core_start, 1);
      check_eq("core_angle_start", core_angle, ga);
      check_eq("busy_start", busy, 1);
      check_eq("ready0_start", req0_ready, 0);
      check_eq("ready1_start", req1_ready, 0);
      c = W'($urandom);
      s = W'($urandom);
      exp = (dly > 0) ? {gid, 1'b0, c, s} : {gid, 1'b1, {W{1'b0}}, {W{1'b0}}};
      exp_q.push_back(exp);
      limit = (dly > 0) ? dly : TO;
      for (int i = 1; i <= limit; i++) begin
         @(negedge clock);
         core_done = 1'b0;
         core_cos  = W'($urandom);
         core_sin  = W'($urandom);
         check_eq("core_start_wait", core_start, 0);
         check_eq("core_angle_wait", core_angle, ga);
         check_eq("rsp_valid_early", rsp_valid, 0);
         check_eq("ready0_wait", req0_ready, 0);
         check_eq("ready1_wait", req1_ready, 0);
         if (dly > 0 && i == dly) begin
            core_done = 1'b1; core_cos = c; core_sin = s;
         end
      end
      @(negedge clock);
      core_done = 1'b0;
      for (int i = 0; i < bp; i++) begin
         #1;
         check_rsp(exp_q[0]);
         // A stray strobe while the response is pending must not disturb it.
         core_done = 1'($urandom_range(0, 1));
         core_cos  = W'($urandom);
         core_sin  = W'($urandom);
         @(negedge clock);
      end
      rsp_ready = 1'b1;
      #1;
      check_rsp(exp_q.pop_front());
      @(negedge clock);
      rsp_ready = 1'b0;
      core_done = 1'b0;
      #1;
      check_eq("rsp_valid_after", rsp_valid, 0);
      check_eq("busy_after", busy, 0);
   endtask

   task automatic check_quiet(input string tag);
      check_eq({tag, "_busy"}, busy, 0);
      check_eq({tag, "_rsp_valid"}, rsp_valid, 0);
      check_eq({tag, "_core_start"}, core_start, 0);
      check_eq({tag, "_state"}, dbg_state, 0);
   endtask

   initial begin
      reset_n = 1'b0;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_angle = '0; req1_angle = '0;
      core_done = 1'b0; core_cos = '0; core_sin = '0;
      rsp_ready = 1'b0;
      model_last = 1'b1;
      repeat (3) @(negedge clock);

      // Reset values
      check_quiet("reset");
      check_eq("reset_ready0", req0_ready, 0);
      check_eq("reset_ready1", req1_ready, 0);
      check_eq("reset_core_angle", core_angle, 0);
      check_eq("reset_rsp_id", rsp_id, 0);
      check_eq("reset_rsp_cos", rsp_cos, 0);
      check_eq("reset_rsp_sin", rsp_sin, 0);
      check_eq("reset_rsp_err", rsp_err, 0);
      reset_n = 1'b1;
      @(negedge clock);

      // Simultaneous requests from reset: req0, then held req1, then tie -> req0
      run_txn(1, 1, 18'h00111, 18'h00222, 5, 0);
      run_txn(0, 1, 18'h00333, 18'h00222, 3, 1);
      run_txn(1, 1, 18'h00444, 18'h00555, 7, 0);
      req1_valid = 1'b0;
      @(negedge clock);

      // Single request with the reference values
      run_txn(1, 0, 18'h04000, 18'h0, 16, 0);
      exp_q.push_back({1'b0, 1'b0, 18'h1ABCD, 18'h0F00F});
      // Directed result check: drive the known core outputs explicitly
      req0_valid = 1'b1; req0_angle = 18'h04000;
      #1;
      check_eq("dir_ready0", req0_ready, 1);
      @(posedge clock); model_last = 1'b0;
      @(negedge clock); req0_valid = 1'b0;
      #1;
      check_eq("dir_core_start", core_start, 1);
      check_eq("dir_core_angle", core_angle, 18'h04000);
      repeat (16) @(negedge clock);
      core_done = 1'b1; core_cos = 18'h1ABCD; core_sin = 18'h0F00F;
      @(negedge clock);
      core_done = 1'b0;
      rsp_ready = 1'b1;
      #1;
      check_rsp(exp_q.pop_front());
      @(negedge clock);
      rsp_ready = 1'b0;

      // Timeout and backpressure
      run_txn(1, 0, 18'h12345, 18'h0, 0, 2);
      run_txn(0, 1, 18'h0, 18'h2AAAA, 9, 10);

      // Spurious core_done in IDLE
      core_done = 1'b1; core_cos = 18'h3FFFF; core_sin = 18'h3FFFF;
      @(negedge clock);
      core_done = 1'b0;
      repeat (2) begin
         #1;
         check_quiet("spurious_idle");
         @(negedge clock);
      end

      // Reset while waiting on the core, then a late core_done
      req0_valid = 1'b1; req0_angle = 18'h01010;
      @(posedge clock);
      @(negedge clock); req0_valid = 1'b0;
      repeat (4) @(negedge clock);
      reset_n = 1'b0;
      @(negedge clock);
      check_quiet("reset_wait");
      reset_n = 1'b1;
      model_last = 1'b1;
      core_done = 1'b1; core_cos = 18'h15555; core_sin = 18'h0AAAA;
      @(negedge clock);
      core_done = 1'b0;
      repeat (4) begin
         #1;
         check_quiet("after_reset");
         @(negedge clock);
      end
      run_txn(0, 1, 18'h0, 18'h00777, 4, 0);
      run_txn(1, 1, 18'h00888, 18'h00999, 2, 0);

      // Randomised traffic
      for (int n = 0; n < 20; n++) begin
         int pat, dly;
         pat = $urandom_range(1, 3);
         dly = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 30);
         run_txn(pat[0], pat[1], W'($urandom), W'($urandom), dly, $urandom_range(0, 3));
         req0_valid = 1'b0; req1_valid = 1'b0;
         if ($urandom_range(0, 1) == 1) @(negedge clock);
      end

      check_eq("exp_q_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
